// File: rtl/out_port_fifo_if.sv
// Output-port FIFO bus: capture side (wr_*), consumer handshake (out_*) and status.
// master = CPU/consumer side driving strobes, slave = the FIFO.
// ovf_count exists only when OUT_PORT_OVF_CNT_EN is defined.
interface out_port_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
`ifdef OUT_PORT_OVF_CNT_EN
  logic [7:0]       ovf_count;

  modport master (
    output wr_en, wr_data, out_ready,
    input  out_data, out_valid, full, empty, count, overflow, ovf_count
  );
  modport slave (
    input  wr_en, wr_data, out_ready,
    output out_data, out_valid, full, empty, count, overflow, ovf_count
  );
`else
  modport master (
    output wr_en, wr_data, out_ready,
    input  out_data, out_valid, full, empty, count, overflow
  );
  modport slave (
    input  wr_en, wr_data, out_ready,
    output out_data, out_valid, full, empty, count, overflow
  );
`endif
endinterface

// File: rtl/out_port_fifo.sv
// Purpose: output-port queue capturing every OUT word; drops and flags writes when full.
// Latency: word written at edge N is visible (show-ahead) from cycle N+1; no fall-through.
// Backpressure: consumer stalls via out_ready; producer never stalls, full+no-read drops.
// Optional: OUT_PORT_OVF_CNT_EN adds a saturating 8-bit dropped-write counter.
module out_port_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic            clk,
  input logic            rst,
  out_port_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             ovf_sticky;
  logic             is_empty;
  logic             is_full;
  logic             rd_fire;
  logic             wr_acc;
  logic             wr_drop;

  // Status is derived from occupancy only, so pointer wrap never aliases full/empty.
  always_comb begin
    is_empty = (cnt == '0);
    is_full  = (cnt == FULL_CNT);
    rd_fire  = ~is_empty & bus.out_ready;
    // A full queue can still take a word when the head leaves in the same cycle.
    wr_acc   = bus.wr_en & (~is_full | rd_fire);
    wr_drop  = bus.wr_en & ~wr_acc;
  end

  // Storage is deliberately not reset; writes are suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Pointer, occupancy and sticky-overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (wr_acc && !rd_fire) begin
        cnt <= cnt + CNT_W'(1);
      end else if (rd_fire && !wr_acc) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (wr_drop) begin
        ovf_sticky <= 1'b1;
      end
    end
  end

`ifdef OUT_PORT_OVF_CNT_EN
  logic [7:0] ovf_cnt;

  // Dropped-write counter saturates at 8'hFF rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= 8'h00;
    end else if (wr_drop && ovf_cnt != 8'hFF) begin
      ovf_cnt <= ovf_cnt + 8'h01;
    end
  end

  assign bus.ovf_count = ovf_cnt;
`endif

  // Show-ahead head word; forced to zero when nothing is queued.
  always_comb begin
    bus.out_data  = is_empty ? '0 : mem[rd_ptr];
    bus.out_valid = ~is_empty;
    bus.full      = is_full;
    bus.empty     = is_empty;
    bus.count     = cnt;
    bus.overflow  = ovf_sticky;
  end
endmodule

// File: tb/tb_out_port_fifo.sv
// Bench for out_port_fifo: directed vectors, queue-based reference model checked
// every cycle on the falling edge, plus literal expectations at key points.
// Inputs change 1 time unit after the rising edge.
module tb_out_port_fifo;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  out_port_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  out_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [WIDTH-1:0] mq [$];
  bit               m_ovf = 1'b0;
  int               m_ovfc = 0;
  // Words the DUT actually handed to the consumer
  logic [WIDTH-1:0] rxq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: update from the rules, using inputs that are stable around the edge.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_ovfc = 0;
    end else begin
      bit rd;
      bit wr;
      rd = (mq.size() > 0) && bus.out_ready;
      wr = bus.wr_en && ((mq.size() < DEPTH) || rd);
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back(bus.wr_data);
      else if (bus.wr_en) begin
        m_ovf = 1'b1;
        if (m_ovfc < 255) m_ovfc++;
      end
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      check("out_data",  32'(bus.out_data),  (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
      check("count",     32'(bus.count),     32'(mq.size()));
      check("full",      32'(bus.full),      32'(mq.size() == DEPTH));
      check("empty",     32'(bus.empty),     32'(mq.size() == 0));
      check("overflow",  32'(bus.overflow),  32'(m_ovf));
`ifdef OUT_PORT_OVF_CNT_EN
      check("ovf_count", 32'(bus.ovf_count), 32'(m_ovfc));
`endif
      if (bus.out_valid && bus.out_ready) rxq.push_back(bus.out_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.out_ready = 1'b0;
    cyc();
    rst = 1'b0;
    rxq.delete();
  endtask

  task automatic wr(input logic [WIDTH-1:0] d);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    cyc();
    bus.wr_en = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.out_ready = 1'b1;
    repeat (n) cyc();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full",  32'(bus.full), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_ovf",   32'(bus.overflow), 32'd0);
`ifdef OUT_PORT_OVF_CNT_EN
    check("rst_ovfc",  32'(bus.ovf_count), 32'd0);
`endif

    // Single word held under backpressure
    wr(16'hBEEF);
    check("beef_valid", 32'(bus.out_valid), 32'd1);
    check("beef_data",  32'(bus.out_data), 32'hBEEF);
    check("beef_count", 32'(bus.count), 32'd1);
    check("beef_empty", 32'(bus.empty), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("beef_hold", 32'(bus.out_data), 32'hBEEF);
    end
    drain(1);
    check("beef_gone_valid", 32'(bus.out_valid), 32'd0);
    check("beef_gone_data",  32'(bus.out_data), 32'd0);
    check("beef_rx_n", 32'(rxq.size()), 32'd1);
    if (rxq.size() == 1) check("beef_rx", 32'(rxq[0]), 32'hBEEF);
    rxq.delete();

    // Fill, overflow, drain in order
    for (int i = 1; i <= 8; i++) wr(16'(i));
    check("fill_full",  32'(bus.full), 32'd1);
    check("fill_count", 32'(bus.count), 32'd8);
    wr(16'h0009);
    check("drop_ovf",   32'(bus.overflow), 32'd1);
    check("drop_count", 32'(bus.count), 32'd8);
`ifdef OUT_PORT_OVF_CNT_EN
    check("drop_ovfc",  32'(bus.ovf_count), 32'd1);
`endif
    drain(8);
    check("drain_n", 32'(rxq.size()), 32'd8);
    for (int i = 0; i < 8 && i < rxq.size(); i++) check("drain_seq", 32'(rxq[i]), 32'(i + 1));
    check("drain_empty", 32'(bus.empty), 32'd1);

    // Simultaneous write and read on a full queue
    do_reset();
    for (int i = 1; i <= 8; i++) wr(16'(i));
    bus.wr_en = 1'b1;
    bus.wr_data = 16'h00AA;
    bus.out_ready = 1'b1;
    cyc();
    bus.wr_en = 1'b0;
    bus.out_ready = 1'b0;
    check("rw_full_count", 32'(bus.count), 32'd8);
    check("rw_full_ovf",   32'(bus.overflow), 32'd0);
    check("rw_full_head",  32'(bus.out_data), 32'd2);
    drain(8);
    check("rw_rx_n", 32'(rxq.size()), 32'd9);
    if (rxq.size() == 9) begin
      check("rw_rx_first", 32'(rxq[0]), 32'd1);
      check("rw_rx_last",  32'(rxq[8]), 32'h00AA);
    end

    // Streaming with pointer wrap
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 16'(16'h0100 + i);
      cyc();
      check("stream_cnt_le1", 32'(bus.count <= 1), 32'd1);
    end
    bus.wr_en = 1'b0;
    cyc();
    bus.out_ready = 1'b0;
    check("stream_rx_n", 32'(rxq.size()), 32'd20);
    for (int i = 0; i < 20 && i < rxq.size(); i++) check("stream_seq", 32'(rxq[i]), 32'(16'h0100 + i));
    check("stream_ovf", 32'(bus.overflow), 32'd0);

    // Reset mid-transfer
    do_reset();
    for (int i = 0; i < 5; i++) wr(16'(16'h0A00 + i));
    check("pre_rst_count", 32'(bus.count), 32'd5);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    rxq.delete();
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_ovf",   32'(bus.overflow), 32'd0);
    wr(16'h1234);
    check("post_rst_data",  32'(bus.out_data), 32'h1234);
    check("post_rst_count", 32'(bus.count), 32'd1);
    drain(2);
    check("post_rst_rx_n", 32'(rxq.size()), 32'd1);
    if (rxq.size() == 1) check("post_rst_rx", 32'(rxq[0]), 32'h1234);

    // Long overflow burst (saturation when the counter is present)
    do_reset();
    for (int i = 0; i < 8; i++) wr(16'(16'h0C00 + i));
    bus.wr_en = 1'b1;
    for (int i = 0; i < 260; i++) begin
      bus.wr_data = 16'(i);
      cyc();
    end
    bus.wr_en = 1'b0;
    check("sat_ovf",   32'(bus.overflow), 32'd1);
    check("sat_count", 32'(bus.count), 32'd8);
    check("sat_head",  32'(bus.out_data), 32'h0C00);
`ifdef OUT_PORT_OVF_CNT_EN
    check("sat_ovfc",  32'(bus.ovf_count), 32'hFF);
`endif
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the directed sequence is fixed-length; this only guards against hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
